// File: rtl/i2s_video_rx.sv
// i2s_video_rx
//   Receive side of the monochrome I2S video link. The serial stream is
//   oversampled on mclk and rebuilt into 8-bit grey pixels, MSB first. Each
//   pixel is tagged with start-of-frame and end-of-line flags. End of frame
//   is detected when bclk stays inactive. Pixels wait in a small FIFO that
//   has a valid/ready output.
//
// Ports
//   mclk         system clock, at least 4x the i2s_bclk frequency
//   reset        synchronous active-low reset
//   i2s_bclk     serial bit clock, gated low between frames
//   i2s_ws       word select, toggles on pixel boundaries
//   i2s_data     serial pixel data, MSB first
//   pixel_data   grey pixel at the FIFO head
//   pixel_sof    head pixel is the first pixel of a frame
//   pixel_eol    head pixel is the last pixel of a line
//   pixel_valid  FIFO not empty
//   pixel_ready  consumer accepts the head pixel when valid && ready
//   frame_done   one-cycle pulse when a frame ends
//   overflow     sticky; a pixel was dropped because the FIFO was full
//
// State table
//   state | meaning
//   IDLE  | no frame in progress; the first bclk rise starts a frame
//   RECV  | frame in progress; bclk inactivity is timed to find its end

module i2s_video_rx #(
    parameter int IMG_W        = 640,
    parameter int IDLE_TIMEOUT = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       i2s_bclk,
    input  logic       i2s_ws,
    input  logic       i2s_data,
    output logic [7:0] pixel_data,
    output logic       pixel_sof,
    output logic       pixel_eol,
    output logic       pixel_valid,
    input  logic       pixel_ready,
    output logic       frame_done,
    output logic       overflow
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX  = '1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    // Input synchronisers. The third bclk stage is used only to detect edges.
    logic bclk_s1_q, bclk_s1_d;
    logic bclk_s2_q, bclk_s2_d;
    logic bclk_s3_q, bclk_s3_d;
    logic ws_s1_q, ws_s1_d;
    logic ws_s2_q, ws_s2_d;
    logic data_s1_q, data_s1_d;
    logic data_s2_q, data_s2_d;

    // Deserialiser and frame tracking.
    logic [0:0]    state_q, state_d;
    logic          last_ws_q, last_ws_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          sof_flag_q, sof_flag_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    // FIFO. Each entry holds {sof, eol, pixel}.
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          rise;
    logic          ws_edge;
    logic          byte_done;
    logic          sof_cur;
    logic [XW-1:0] x_cur;
    logic          push;
    logic [9:0]    push_word;
    logic          pop;
    logic          full;
    logic          wr_en;

    assign rise    = bclk_s2_q & ~bclk_s3_q;
    assign ws_edge = (ws_s2_q != last_ws_q);

    always_comb begin
        bclk_s1_d = i2s_bclk;
        bclk_s2_d = bclk_s1_q;
        bclk_s3_d = bclk_s2_q;
        ws_s1_d   = i2s_ws;
        ws_s2_d   = ws_s1_q;
        data_s1_d = i2s_data;
        data_s2_d = data_s1_q;
    end

    always_comb begin
        state_d      = state_q;
        last_ws_d    = last_ws_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        x_d          = x_q;
        idle_cnt_d   = idle_cnt_q;
        sof_flag_d   = sof_flag_q;
        frame_done_d = 1'b0;
        byte_done    = 1'b0;
        push         = 1'b0;
        push_word    = '0;

        // The rise that starts a frame sees the new sof/x values directly.
        // This keeps the tags right even if that rise also completes a byte.
        sof_cur = (state_q == ST_IDLE) ? 1'b1 : sof_flag_q;
        x_cur   = (state_q == ST_IDLE) ? '0   : x_q;

        if (rise) begin
            shift_d    = {shift_q[6:0], data_s2_q};
            last_ws_d  = ws_s2_q;
            idle_cnt_d = '0;

            if (state_q == ST_IDLE) begin
                state_d    = ST_RECV;
                sof_flag_d = 1'b1;
                x_d        = '0;
            end

            // A ws change marks the MSB of a new pixel. Any bits already
            // shifted in are discarded.
            if (ws_edge) begin
                bit_cnt_d = 3'd1;
            end else if (bit_cnt_q == 3'd7) begin
                byte_done = 1'b1;
                bit_cnt_d = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            // x advances even when the FIFO drops the pixel. This keeps
            // later eol tags aligned with the line.
            if (byte_done) begin
                push       = 1'b1;
                push_word  = {sof_cur, (x_cur == X_LAST), shift_d};
                sof_flag_d = 1'b0;
                x_d        = (x_cur == X_LAST) ? '0 : x_cur + 1'b1;
            end
        end else if (state_q == ST_RECV) begin
            if (idle_cnt_q == IDLE_LAST) begin
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
                bit_cnt_d    = 3'd0;
                shift_d      = 8'd0;
                x_d          = '0;
                idle_cnt_d   = '0;
                sof_flag_d   = 1'b0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    assign pop   = (count_q != '0) && pixel_ready;
    assign full  = (count_q == FIFO_FULL);
    // When the FIFO is full, a pop in the same cycle frees the slot, so the push still fits.
    assign wr_en = push && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && full && !pop);

        if (wr_en) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            bclk_s1_q    <= 1'b0;
            bclk_s2_q    <= 1'b0;
            bclk_s3_q    <= 1'b0;
            ws_s1_q      <= 1'b0;
            ws_s2_q      <= 1'b0;
            data_s1_q    <= 1'b0;
            data_s2_q    <= 1'b0;
            state_q      <= ST_IDLE;
            last_ws_q    <= 1'b0;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            x_q          <= '0;
            idle_cnt_q   <= '0;
            sof_flag_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            bclk_s1_q    <= bclk_s1_d;
            bclk_s2_q    <= bclk_s2_d;
            bclk_s3_q    <= bclk_s3_d;
            ws_s1_q      <= ws_s1_d;
            ws_s2_q      <= ws_s2_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            state_q      <= state_d;
            last_ws_q    <= last_ws_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            x_q          <= x_d;
            idle_cnt_q   <= idle_cnt_d;
            sof_flag_q   <= sof_flag_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    // The head entry holds its value until it is popped. The memory is
    // cleared at reset, so the head reads 0 after reset.
    assign {pixel_sof, pixel_eol, pixel_data} = mem_q[rd_ptr_q];
    assign pixel_valid = (count_q != '0);
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;

endmodule
